solver_dispatch: RTL and testbench



---
 rtl/solver_pkg.sv | 23 ++
 rtl/solver_dispatch_if.sv | 66 ++++++
 rtl/solver_dispatch_rise_detect.sv | 30 +++
 rtl/solver_dispatch.sv | 239 +++++++++++++++++++++++
 tb/tb_solver_dispatch.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/solver_pkg.sv
// Shared types and constants for the solver host-side dispatcher.
// Revision 1.0 - initial release.
`default_nettype none

package solver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIG  = 3'd1,
    ST_LOAD_RE = 3'd2,
    ST_LOAD_IM = 3'd3,
    ST_START   = 3'd4,
    ST_RUN     = 3'd5,
    ST_RESULT  = 3'd6
  } state_e;

  localparam logic [15:0] ITER_LIMIT_HIT    = 16'hFFFF;
  localparam int          DEFAULT_NUM_LIMBS = 1;
  localparam logic [15:0] DEFAULT_ITER_LIM  = 16'd256;

endpackage

`default_nettype wire

// File: rtl/solver_dispatch_if.sv
// Host-side job/result signals plus the solver write/start/done port of the dispatcher.
// Revision 1.0 - initial release.
`default_nettype none

interface solver_dispatch_if #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_WIDTH      = 32,
  parameter int TAG_BITS        = 16
);

  logic                       cfg_wr_en;
  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs;
  logic [15:0]                cfg_iter_lim;

  logic                       in_valid;
  logic                       in_ready;
  logic [LIMB_WIDTH-1:0]      in_data;
  logic [TAG_BITS-1:0]        in_tag;

  logic                       wr_real_en;
  logic                       wr_imag_en;
  logic [LIMB_INDEX_BITS-1:0] wr_ind;
  logic [LIMB_WIDTH-1:0]      c_limb_data;
  logic                       wr_num_limbs_en;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
  logic                       wr_iter_lim_en;
  logic [15:0]                iter_lim_data;
  logic                       start;
  logic                       out_ready;
  logic [15:0]                iteration_count;

  logic                       res_valid;
  logic                       res_ready;
  logic [TAG_BITS-1:0]        res_tag;
  logic [15:0]                res_count;
  logic                       res_escaped;
  logic [31:0]                res_cycles;
  logic                       busy;

  // Dispatcher side.
  modport slave (
    input  cfg_wr_en, cfg_num_limbs, cfg_iter_lim,
    input  in_valid, in_data, in_tag,
    output in_ready,
    output wr_real_en, wr_imag_en, wr_ind, c_limb_data,
    output wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data, start,
    input  out_ready, iteration_count,
    output res_valid, res_tag, res_count, res_escaped, res_cycles, busy,
    input  res_ready
  );

  // Host and solver environment side.
  modport master (
    output cfg_wr_en, cfg_num_limbs, cfg_iter_lim,
    output in_valid, in_data, in_tag,
    input  in_ready,
    input  wr_real_en, wr_imag_en, wr_ind, c_limb_data,
    input  wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data, start,
    output out_ready, iteration_count,
    input  res_valid, res_tag, res_count, res_escaped, res_cycles, busy,
    output res_ready
  );

endinterface

`default_nettype wire

// File: rtl/solver_dispatch_rise_detect.sv
// rise_detect: flags a 0->1 transition of sig_i against its registered previous value.
// Revision 1.0 - initial release.
`default_nettype none

module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sig_i;
      armed_q <= 1'b1;
    end
  end

  // Disarmed for the first cycle out of reset so a level already high is not taken as an edge.
  assign rise_o = armed_q & sig_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/solver_dispatch.sv
// solver_dispatch: loads a job's c limbs into the solver, starts it and returns the tagged count.
// Optional job cycle counter under SOLVER_DISPATCH_PERF_EN. Revision 1.0 - initial release.
`default_nettype none

module solver_dispatch
  import solver_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_WIDTH      = 32,
  parameter int TAG_BITS        = 16
) (
  input logic              clock,
  input logic              reset,
  solver_dispatch_if.slave bus
);

  localparam logic [LIMB_INDEX_BITS-1:0] IDX_ONE = LIMB_INDEX_BITS'(1);

  state_e                     state_q, state_d;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_q;
  logic [15:0]                iter_lim_q;
  logic [LIMB_INDEX_BITS-1:0] job_n_q, job_n_d;
  logic [LIMB_INDEX_BITS-1:0] idx_q, idx_d;
  logic [TAG_BITS-1:0]        tag_q, tag_d;
  logic [LIMB_WIDTH-1:0]      hold_q, hold_d;
  logic                       wr_real_q, wr_real_d;
  logic                       wr_imag_q, wr_imag_d;
  logic [LIMB_INDEX_BITS-1:0] wr_ind_q, wr_ind_d;
  logic [LIMB_WIDTH-1:0]      c_limb_q, c_limb_d;
  logic                       wr_nl_q, wr_nl_d;
  logic [LIMB_INDEX_BITS-1:0] nl_data_q, nl_data_d;
  logic                       wr_il_q, wr_il_d;
  logic [15:0]                il_data_q, il_data_d;
  logic                       start_q, start_d;
  logic [15:0]                res_count_q, res_count_d;
  logic [TAG_BITS-1:0]        res_tag_q, res_tag_d;
  logic                       res_esc_q, res_esc_d;

  logic                       in_ready_w;
  logic                       in_fire_w;
  logic                       done_rise_w;
  logic [LIMB_INDEX_BITS-1:0] last_idx_w;

  rise_detect u_rise_detect (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (bus.out_ready),
    .rise_o (done_rise_w)
  );

  assign in_ready_w = (state_q == ST_IDLE) || (state_q == ST_LOAD_RE) || (state_q == ST_LOAD_IM);
  assign in_fire_w  = bus.in_valid & in_ready_w;
  assign last_idx_w = job_n_q - IDX_ONE;

  // Config is live in every state; the job snapshots it on its first limb.
  always_ff @(posedge clock) begin
    if (reset) begin
      num_limbs_q <= LIMB_INDEX_BITS'(DEFAULT_NUM_LIMBS);
      iter_lim_q  <= DEFAULT_ITER_LIM;
    end else if (bus.cfg_wr_en) begin
      if (bus.cfg_num_limbs != '0) begin
        num_limbs_q <= bus.cfg_num_limbs;
      end
      iter_lim_q <= bus.cfg_iter_lim;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      job_n_q     <= LIMB_INDEX_BITS'(DEFAULT_NUM_LIMBS);
      idx_q       <= '0;
      tag_q       <= '0;
      hold_q      <= '0;
      wr_real_q   <= 1'b0;
      wr_imag_q   <= 1'b0;
      wr_ind_q    <= '0;
      c_limb_q    <= '0;
      wr_nl_q     <= 1'b0;
      nl_data_q   <= '0;
      wr_il_q     <= 1'b0;
      il_data_q   <= '0;
      start_q     <= 1'b0;
      res_count_q <= '0;
      res_tag_q   <= '0;
      res_esc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_n_q     <= job_n_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      hold_q      <= hold_d;
      wr_real_q   <= wr_real_d;
      wr_imag_q   <= wr_imag_d;
      wr_ind_q    <= wr_ind_d;
      c_limb_q    <= c_limb_d;
      wr_nl_q     <= wr_nl_d;
      nl_data_q   <= nl_data_d;
      wr_il_q     <= wr_il_d;
      il_data_q   <= il_data_d;
      start_q     <= start_d;
      res_count_q <= res_count_d;
      res_tag_q   <= res_tag_d;
      res_esc_q   <= res_esc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    job_n_d     = job_n_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    hold_d      = hold_q;
    wr_real_d   = 1'b0;
    wr_imag_d   = 1'b0;
    wr_ind_d    = wr_ind_q;
    c_limb_d    = c_limb_q;
    wr_nl_d     = 1'b0;
    nl_data_d   = nl_data_q;
    wr_il_d     = 1'b0;
    il_data_d   = il_data_q;
    start_d     = 1'b0;
    res_count_d = res_count_q;
    res_tag_d   = res_tag_q;
    res_esc_d   = res_esc_q;

    case (state_q)
      ST_IDLE: begin
        if (in_fire_w) begin
          tag_d     = bus.in_tag;
          hold_d    = bus.in_data;
          job_n_d   = num_limbs_q;
          wr_nl_d   = 1'b1;
          nl_data_d = num_limbs_q;
          wr_il_d   = 1'b1;
          il_data_d = iter_lim_q;
          state_d   = ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        // re[0] was parked in hold_q so the config strobes reach the solver first.
        wr_real_d = 1'b1;
        wr_ind_d  = '0;
        c_limb_d  = hold_q;
        if (job_n_q == IDX_ONE) begin
          idx_d   = '0;
          state_d = ST_LOAD_IM;
        end else begin
          idx_d   = IDX_ONE;
          state_d = ST_LOAD_RE;
        end
      end
      ST_LOAD_RE: begin
        if (in_fire_w) begin
          wr_real_d = 1'b1;
          wr_ind_d  = idx_q;
          c_limb_d  = bus.in_data;
          if (idx_q == last_idx_w) begin
            idx_d   = '0;
            state_d = ST_LOAD_IM;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ST_LOAD_IM: begin
        if (in_fire_w) begin
          wr_imag_d = 1'b1;
          wr_ind_d  = idx_q;
          c_limb_d  = bus.in_data;
          if (idx_q == last_idx_w) begin
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Edge, not level: out_ready is still high from the previous job when start issues.
        if (done_rise_w) begin
          res_count_d = bus.iteration_count;
          res_esc_d   = (bus.iteration_count != ITER_LIMIT_HIT);
          res_tag_d   = tag_q;
          state_d     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready        = in_ready_w;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.res_valid       = (state_q == ST_RESULT);
  assign bus.wr_real_en      = wr_real_q;
  assign bus.wr_imag_en      = wr_imag_q;
  assign bus.wr_ind          = wr_ind_q;
  assign bus.c_limb_data     = c_limb_q;
  assign bus.wr_num_limbs_en = wr_nl_q;
  assign bus.num_limbs_data  = nl_data_q;
  assign bus.wr_iter_lim_en  = wr_il_q;
  assign bus.iter_lim_data   = il_data_q;
  assign bus.start           = start_q;
  assign bus.res_count       = res_count_q;
  assign bus.res_tag         = res_tag_q;
  assign bus.res_escaped     = res_esc_q;

`ifdef SOLVER_DISPATCH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (in_fire_w) begin
        perf_q <= '0;
      end
    end else if ((state_q != ST_RESULT) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.res_cycles = perf_q;
`else
  assign bus.res_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_solver_dispatch.sv
// Self-checking bench for solver_dispatch with a behavioural solver and expected write-log model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_solver_dispatch;

  logic clock = 1'b0;
  logic reset = 1'b1;

  solver_dispatch_if #(.LIMB_INDEX_BITS(6), .LIMB_WIDTH(32), .TAG_BITS(16)) bus ();

  solver_dispatch #(.LIMB_INDEX_BITS(6), .LIMB_WIDTH(32), .TAG_BITS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Solver model: out_ready drops one cycle after start is seen, rises sv_s cycles after start.
  int          sv_s = 4;
  logic [15:0] sv_count = '0;
  bit          sv_running = 1'b0;
  bit          sv_rose = 1'b0;
  int          drop_at = 0;
  int          rise_at = 0;

  initial begin
    bus.out_ready       = 1'b1;
    bus.iteration_count = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus.out_ready = 1'b1;
        sv_running    = 1'b0;
      end else if (bus.start) begin
        drop_at    = cyc + 1;
        rise_at    = cyc + sv_s;
        sv_running = 1'b1;
        sv_rose    = 1'b0;
      end else if (sv_running) begin
        if (cyc == drop_at) bus.out_ready = 1'b0;
        if (cyc == rise_at) begin
          bus.out_ready       = 1'b1;
          bus.iteration_count = sv_count;
          sv_running          = 1'b0;
          sv_rose             = 1'b1;
        end
      end
    end
  end

  // Log of everything the dispatcher drives toward the solver.
  typedef struct {
    int          kind;   // 0 num_limbs, 1 iter_lim, 2 real, 3 imag, 4 start
    int          idx;
    logic [31:0] data;
    int          c;
  } ev_t;
  ev_t log_q[$];

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.wr_num_limbs_en) log_q.push_back('{0, 0, 32'(bus.num_limbs_data), cyc});
        if (bus.wr_iter_lim_en)  log_q.push_back('{1, 0, 32'(bus.iter_lim_data), cyc});
        if (bus.wr_real_en)      log_q.push_back('{2, int'(bus.wr_ind), bus.c_limb_data, cyc});
        if (bus.wr_imag_en)      log_q.push_back('{3, int'(bus.wr_ind), bus.c_limb_data, cyc});
        if (bus.start)           log_q.push_back('{4, 0, 32'd0, cyc});
      end
    end
  end

  function automatic logic [47:0] pack_ev(input int kind, input int idx, input logic [31:0] data);
    return {8'(kind), 8'(idx), data};
  endfunction

  int          model_n   = 1;
  int          model_lim = 256;
  logic [31:0] re_l[64];
  logic [31:0] im_l[64];
  int          h_cyc = 0;

  task automatic do_cfg(input int n, input int lim);
    bus.cfg_wr_en     = 1'b1;
    bus.cfg_num_limbs = 6'(n);
    bus.cfg_iter_lim  = 16'(lim);
    @(negedge clock);
    bus.cfg_wr_en = 1'b0;
    if (n != 0) model_n = n;
    model_lim = lim;
  endtask

  // Streams re[0..n-1] then im[0..], total limbs, optionally with in_valid gaps.
  task automatic feed(input int n, input int total, input logic [15:0] tag, input bit gaps);
    for (int k = 0; k < total; k++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (k < n) ? re_l[k] : im_l[k - n];
      bus.in_tag   = (k == 0) ? tag : 16'($urandom);
      for (int w = 0; w < 200 && !bus.in_ready; w++) @(negedge clock);
      check("in_ready_wait", bus.in_ready, 1'b1);
      if (k == 0) h_cyc = cyc;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] tag, input int s, input logic [15:0] count,
                         input bit gaps, input int hold, input bit preset);
    int          n;
    int          lim;
    int          v;
    int          exp_cycles;
    logic [47:0] exp_ev[$];
    n   = model_n;
    lim = model_lim;
    log_q.delete();
    sv_s     = s;
    sv_count = count;
    if (!preset) begin
      for (int i = 0; i < n; i++) begin
        re_l[i] = $urandom;
        im_l[i] = $urandom;
      end
    end
    feed(n, 2 * n, tag, gaps);

    for (int w = 0; w < 1000 && !bus.res_valid; w++) @(negedge clock);
    v = cyc;
    check("res_valid_wait", bus.res_valid, 1'b1);
    check("no_stale_level", sv_rose, 1'b1);
    check("res_tag", bus.res_tag, tag);
    check("res_count", bus.res_count, count);
    check("res_escaped", bus.res_escaped, (count != 16'hFFFF));
`ifdef SOLVER_DISPATCH_PERF_EN
    exp_cycles = v - h_cyc - 1;
`else
    exp_cycles = 0;
`endif
    check("res_cycles", bus.res_cycles, 32'(exp_cycles));

    exp_ev.push_back(pack_ev(0, 0, 32'(n)));
    exp_ev.push_back(pack_ev(1, 0, 32'(lim)));
    for (int i = 0; i < n; i++) exp_ev.push_back(pack_ev(2, i, re_l[i]));
    for (int i = 0; i < n; i++) exp_ev.push_back(pack_ev(3, i, im_l[i]));
    exp_ev.push_back(pack_ev(4, 0, 32'd0));
    check("log_len", log_q.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size(); i++) begin
      check("log_event", (i < log_q.size()) ? pack_ev(log_q[i].kind, log_q[i].idx, log_q[i].data)
                                            : 48'hDEAD_DEAD_DEAD, exp_ev[i]);
    end
    if (log_q.size() >= 3) begin
      check("cfg_cycle", log_q[0].c, h_cyc + 1);
      check("start_after_im", log_q[log_q.size() - 1].c, log_q[log_q.size() - 2].c + 1);
    end

    for (int i = 0; i < hold; i++) begin
      check("result_hold", {bus.res_valid, bus.in_ready, bus.busy, bus.res_count, bus.res_tag},
            {1'b1, 1'b0, 1'b1, count, tag});
      @(negedge clock);
    end
    bus.res_ready = 1'b1;
    @(negedge clock);
    bus.res_ready = 1'b0;
    check("idle_after_result", {bus.busy, bus.res_valid, bus.in_ready}, 3'b001);
  endtask

  initial begin
    bus.cfg_wr_en     = 1'b0;
    bus.cfg_num_limbs = '0;
    bus.cfg_iter_lim  = '0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.in_tag        = '0;
    bus.res_ready     = 1'b0;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_handshake", {bus.in_ready, bus.busy, bus.res_valid}, 3'b100);
    check("rst_strobes", {bus.wr_real_en, bus.wr_imag_en, bus.wr_num_limbs_en,
                          bus.wr_iter_lim_en, bus.start}, 5'b0);
    check("rst_data", {bus.wr_ind, bus.c_limb_data, bus.num_limbs_data, bus.iter_lim_data}, 64'd0);
    check("rst_result", {bus.res_count, bus.res_tag, bus.res_escaped}, 64'd0);
    check("rst_cycles", bus.res_cycles, 32'd0);

    // Directed N=2 job with known limbs.
    do_cfg(2, 100);
    re_l[0] = 32'hAAAA_0001; re_l[1] = 32'hBBBB_0002;
    im_l[0] = 32'hCCCC_0003; im_l[1] = 32'hDDDD_0004;
    run_job(16'h0005, 8, 16'd37, 1'b0, 0, 1'b1);

    // Limit hit, result held while the host stalls.
    run_job(16'h0077, 6, 16'hFFFF, 1'b0, 10, 1'b0);

    // Back-to-back: out_ready remains high between jobs.
    run_job(16'($urandom), 3, 16'($urandom_range(0, 65534)), 1'b0, 0, 1'b0);
    run_job(16'($urandom), 5, 16'($urandom_range(0, 65534)), 1'b0, 0, 1'b0);

    // Zero limb count ignored, iteration limit still taken.
    do_cfg(0, 300);
    run_job(16'h0123, 4, 16'd9, 1'b0, 0, 1'b0);

    // Single-limb job.
    do_cfg(1, 50);
    run_job(16'h0456, 3, 16'd1, 1'b0, 1, 1'b0);

    // Randomized jobs with input gaps.
    for (int j = 0; j < 5; j++) begin
      do_cfg($urandom_range(1, 5), $urandom_range(1, 1000));
      run_job(16'($urandom), $urandom_range(2, 20),
              ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65534)),
              1'b1, $urandom_range(0, 3), 1'b0);
    end

    // Long solve.
    do_cfg(2, 500);
    run_job(16'h0BEE, 50, 16'd444, 1'b0, 0, 1'b0);

    // Reset while loading imaginary limbs.
    do_cfg(2, 77);
    for (int i = 0; i < 2; i++) begin
      re_l[i] = $urandom;
      im_l[i] = $urandom;
    end
    feed(2, 3, 16'h0999, 1'b0);
    check("pre_reset_loading", {bus.busy, bus.in_ready}, 2'b11);
    reset = 1'b1;
    @(negedge clock);
    check("reset_idle", {bus.busy, bus.in_ready, bus.res_valid}, 3'b010);
    check("reset_strobes", {bus.wr_real_en, bus.wr_imag_en, bus.wr_num_limbs_en,
                            bus.wr_iter_lim_en, bus.start}, 5'b0);
    @(negedge clock);
    reset     = 1'b0;
    model_n   = 1;
    model_lim = 256;
    @(negedge clock);

    // Recovery job on reset config.
    run_job(16'h0ABC, 7, 16'd200, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
